// File: rtl/riscv_pkg.sv
// Shared RV64I types and sizes used by the integer register file.
package riscv_pkg;
    localparam int XLEN       = 64;
    localparam int NREGS      = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;
endpackage

// File: rtl/regfile_if.sv
// Decode read ports, Writeback write port and the retired-write counter of the regfile.
interface regfile_if
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter int AW   = riscv_pkg::REG_ADDR_W
);
    logic [AW-1:0]   A1_D;
    logic [AW-1:0]   A2_D;
    logic [XLEN-1:0] RD1_D;
    logic [XLEN-1:0] RD2_D;
    logic            RegWrite_W;
    logic [AW-1:0]   Rd_W;
    logic [XLEN-1:0] Result_W;
    logic [63:0]     WriteCount;

    modport master (
        output A1_D, A2_D, RegWrite_W, Rd_W, Result_W,
        input  RD1_D, RD2_D, WriteCount
    );

    modport slave (
        input  A1_D, A2_D, RegWrite_W, Rd_W, Result_W,
        output RD1_D, RD2_D, WriteCount
    );
endinterface

// File: rtl/regfile_rdport.sv
// One combinational read port: stored value, x0 and reset force zero.
// Same-cycle write-through forwarding only when REGFILE_BYPASS_EN is defined.
module regfile_rdport
    import riscv_pkg::*;
#(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int NREGS = riscv_pkg::NREGS,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                       rst,
    input  logic [AW-1:0]              i_addr,
    input  logic [NREGS-1:0][XLEN-1:0] i_regs,
    input  logic                       i_we,
    input  logic [AW-1:0]              i_wa,
    input  logic [XLEN-1:0]            i_wd,
    output logic [XLEN-1:0]            o_data
);
`ifdef REGFILE_BYPASS_EN
    logic w_fwd;
    assign w_fwd = i_we && (i_wa != '0) && (i_wa == i_addr);
`else
    logic w_unused_wr;
    assign w_unused_wr = ^{i_we, i_wa, i_wd};
`endif

    always_comb begin
        o_data = i_regs[i_addr];
`ifdef REGFILE_BYPASS_EN
        if (w_fwd)
            o_data = i_wd;
`endif
        // zero wins over forwarding so x0 and in-reset reads are always 0
        if (rst || i_addr == '0)
            o_data = '0;
    end
endmodule

// File: rtl/regfile.sv
// RV64I integer register file: 32x64 storage, two read ports, one write port, write counter.
// Optional build macro: REGFILE_BYPASS_EN (same-cycle WB-to-Decode forwarding).
module regfile
    import riscv_pkg::*;
#(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int NREGS = riscv_pkg::NREGS
) (
    input logic      clk,
    input logic      rst,
    regfile_if.slave bus
);
    localparam int AW     = $clog2(NREGS);
    localparam int NPORTS = 2;

    logic [NREGS-1:0][XLEN-1:0]  r_regs;
    logic [63:0]                 r_count;
    logic                        w_we;
    logic [NPORTS-1:0][AW-1:0]   w_addr;
    logic [NPORTS-1:0][XLEN-1:0] w_rd;

    // Rd_W/Result_W may be X while RegWrite_W is low; the AND keeps w_we clean
    assign w_we = bus.RegWrite_W && (bus.Rd_W != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_regs  <= '0;
            r_count <= '0;
        end else if (w_we) begin
            r_regs[bus.Rd_W] <= bus.Result_W;
            r_count          <= r_count + 64'd1;
        end
    end

    assign w_addr[0] = bus.A1_D;
    assign w_addr[1] = bus.A2_D;

    genvar g;
    generate
        for (g = 0; g < NPORTS; g++) begin : g_rdport
            regfile_rdport #(
                .XLEN  (XLEN),
                .NREGS (NREGS),
                .AW    (AW)
            ) u_rdport (
                .rst    (rst),
                .i_addr (w_addr[g]),
                .i_regs (r_regs),
                .i_we   (bus.RegWrite_W),
                .i_wa   (bus.Rd_W),
                .i_wd   (bus.Result_W),
                .o_data (w_rd[g])
            );
        end
    endgenerate

    assign bus.RD1_D      = w_rd[0];
    assign bus.RD2_D      = w_rd[1];
    assign bus.WriteCount = r_count;
endmodule
